syncer: RTL and testbench

SYNCER -- requirements
Module: syncer

---
 rtl/syncer.sv | 124 ++++++++++++
 tb/tb_syncer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/syncer.sv
// Receives opponent frames over an asynchronous 3-wire serial link (sel/clk/data),
// validates them, and presents the record aligned with a snapshot of the local location.
module syncer #(
   parameter int unsigned DATA_WIDTH = 89
) (
   input  logic                  clk_pixel_in,
   input  logic                  rst_in,
   input  logic [62:0]           location_in,
   input  logic                  location_in_valid,
   input  logic                  data_in,
   input  logic                  data_clk_in,
   input  logic                  sel_in,
   output logic [62:0]           player_location_out,
   output logic [DATA_WIDTH-1:0] opponent_data_out,
   output logic                  opponent_scored_out,
   output logic                  data_out_valid
);

   localparam int unsigned FRAME_W = DATA_WIDTH + 1;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);

   logic sel_meta, sel_sync;
   logic dclk_meta, dclk_sync;
   logic data_meta, data_sync;

   logic sel_active_q, dclk_q;
   logic start_p, end_p, shift_p, bit_p;
   logic sel_active_c, dclk_rise_c;

   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   bit_cnt;
   logic [62:0]        loc_q;
   logic               frame_ok_c;

   // 2-flop synchronizers; reset to the idle line levels so release makes no edge
   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         sel_meta  <= 1'b1;
         sel_sync  <= 1'b1;
         dclk_meta <= 1'b0;
         dclk_sync <= 1'b0;
         data_meta <= 1'b0;
         data_sync <= 1'b0;
      end else begin
         sel_meta  <= sel_in;
         sel_sync  <= sel_meta;
         dclk_meta <= data_clk_in;
         dclk_sync <= dclk_meta;
         data_meta <= data_in;
         data_sync <= data_meta;
      end
   end

   // History keeps "frame active" (inverted sel), so its reset value of 0 means idle
   assign sel_active_c = ~sel_sync;
   assign dclk_rise_c  = dclk_sync & ~dclk_q;

   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         sel_active_q <= 1'b0;
         dclk_q       <= 1'b0;
         start_p      <= 1'b0;
         end_p        <= 1'b0;
         shift_p      <= 1'b0;
         bit_p        <= 1'b0;
      end else begin
         sel_active_q <= sel_active_c;
         dclk_q       <= dclk_sync;
         start_p      <= sel_active_c & ~sel_active_q;
         end_p        <= ~sel_active_c & sel_active_q;
         shift_p      <= dclk_rise_c & sel_active_c;
         bit_p        <= data_sync;
      end
   end

   // Shift register and saturating bit counter; a start pulse wins over a shift
   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (start_p) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (shift_p) begin
         if (bit_cnt < CNT_FULL) begin
            shreg   <= {shreg[FRAME_W-2:0], bit_p};
            bit_cnt <= bit_cnt + CNT_W'(1);
         end else begin
            bit_cnt <= CNT_OVER;
         end
      end
   end

   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         loc_q <= '0;
      end else if (location_in_valid) begin
         loc_q <= location_in;
      end
   end

   assign frame_ok_c = (bit_cnt == CNT_FULL) && shreg[FRAME_W-1];

   // A strobe in the acceptance cycle bypasses the latch so the newest location is used
   always_ff @(posedge clk_pixel_in or negedge rst_in) begin
      if (!rst_in) begin
         player_location_out <= '0;
         opponent_data_out   <= '0;
         opponent_scored_out <= 1'b0;
         data_out_valid      <= 1'b0;
      end else begin
         data_out_valid <= 1'b0;
         if (end_p && frame_ok_c) begin
            opponent_data_out   <= shreg[DATA_WIDTH-1:0];
            opponent_scored_out <= shreg[0];
            player_location_out <= location_in_valid ? location_in : loc_q;
            data_out_valid      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_syncer.sv
// Directed bench for syncer: table of frames plus hand sequences for reset, idle clocks
// and location-strobe timing around acceptance.
module tb_syncer;
   localparam int unsigned DW = 89;

   localparam logic [89:0] F1 = 90'b101_00000100001_1010101010_11111011111_0101010101_10101010101_0101010101_00_10101010101_0101010101_0;
   localparam logic [62:0] L1 = 63'b11100100001_1111111010_11100011111_0101011101_10101010101_0101010101;
   localparam logic [62:0] L2 = 63'b00000100001_1111111010_11100011111_0101011101_10101010101_0101010101;
   localparam logic [89:0] F2 = {1'b1, 2'b10, 11'b00011101101, 52'hABCDEF0123456, 2'b11, 11'd5, 10'd7, 1'b0};
   localparam logic [89:0] F3 = {1'b1, 2'b01, 63'h3123456789ABCDEF, 2'b00, 11'd1000, 10'd512, 1'b1};
   localparam logic [89:0] F4 = {1'b1, 2'b11, 63'h0, 2'b10, 11'h7FF, 10'h155, 1'b1};
   localparam logic [62:0] L3 = 63'h1F0F0F0F0F0F0F0F;
   localparam logic [62:0] L4 = 63'h0123456789ABCDEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [62:0]   location_in;
   logic          location_in_valid;
   logic          data_in, data_clk_in, sel_in;
   logic [62:0]   player_location_out;
   logic [DW-1:0] opponent_data_out;
   logic          opponent_scored_out;
   logic          data_out_valid;

   syncer #(.DATA_WIDTH(DW)) dut (
      .clk_pixel_in       (clk),
      .rst_in             (rst_n),
      .location_in        (location_in),
      .location_in_valid  (location_in_valid),
      .data_in            (data_in),
      .data_clk_in        (data_clk_in),
      .sel_in             (sel_in),
      .player_location_out(player_location_out),
      .opponent_data_out  (opponent_data_out),
      .opponent_scored_out(opponent_scored_out),
      .data_out_valid     (data_out_valid)
   );

   typedef struct {
      int          nbits;
      logic [90:0] bits;
      int          mode;    // 0 no strobe, 1 strobe before frame, 2 strobe mid-frame
      logic [62:0] loc;
      logic        acc;
      logic        coin;    // strobe coinciding with the acceptance cycle
      logic [62:0] cloc;
   } vec_t;

   vec_t vecs[7];

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   int exp_pulses = 0;
   logic [DW-1:0] exp_data = '0;
   logic [62:0]   exp_loc = '0;
   logic [62:0]   loc_model = '0;

   always @(negedge clk) if (data_out_valid === 1'b1) pulses++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [62:0] v);
      location_in = v;
      location_in_valid = 1'b1;
      tick(1);
      location_in_valid = 1'b0;
      loc_model = v;
   endtask

   task automatic send_frame(input int nbits, input logic [90:0] bits, input int strobe_at,
                             input logic [62:0] loc);
      sel_in = 1'b0;
      tick(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         if (i == strobe_at) strobe(loc);
         data_in = bits[i];
         tick(2);
         data_clk_in = 1'b1;
         tick(3);
         data_clk_in = 1'b0;
      end
      tick(3);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_data"},   128'(opponent_data_out),   128'(exp_data));
      check({tag, "_scored"}, 128'(opponent_scored_out), 128'(exp_data[0]));
      check({tag, "_loc"},    128'(player_location_out), 128'(exp_loc));
   endtask

   task automatic end_frame(input string tag, input logic accept, input logic coin,
                            input logic [62:0] cloc, input logic [88:0] fbits);
      if (accept) begin
         exp_data = fbits;
         exp_loc  = coin ? cloc : loc_model;
         exp_pulses++;
      end
      sel_in = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         if (coin && k == 4) begin
            location_in = cloc;
            location_in_valid = 1'b1;
         end
         if (coin && k == 5) location_in_valid = 1'b0;
         tick(1);
         check({tag, "_valid_t", $sformatf("%0d", k)}, 128'(data_out_valid),
               128'(accept && k == 4));
      end
      if (coin) loc_model = cloc;
      check_outputs(tag);
      tick(3);
   endtask

   initial begin
      vecs[0] = '{90, 91'(F1), 2, L1, 1'b1, 1'b0, 63'h0};
      vecs[1] = '{90, 91'(F2), 1, L2, 1'b1, 1'b0, 63'h0};
      vecs[2] = '{89, 91'(F1[88:0]), 0, 63'h0, 1'b0, 1'b0, 63'h0};
      vecs[3] = '{91, {1'b1, F1}, 0, 63'h0, 1'b0, 1'b0, 63'h0};
      vecs[4] = '{90, 91'({1'b0, F1[88:0]}), 0, 63'h0, 1'b0, 1'b0, 63'h0};
      vecs[5] = '{90, 91'(F4), 1, L1, 1'b1, 1'b1, L4};
      vecs[6] = '{90, 91'(F3), 2, L3, 1'b1, 1'b0, 63'h0};

      rst_n = 1'b0;
      location_in = '0;
      location_in_valid = 1'b0;
      data_in = 1'b0;
      data_clk_in = 1'b0;
      sel_in = 1'b1;
      tick(3);
      check_outputs("reset");
      check("reset_valid", 128'(data_out_valid), 128'(0));
      rst_n = 1'b1;
      tick(5);
      check_outputs("post_reset");
      check("post_reset_pulses", 128'(pulses), 128'(0));

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].mode == 1) begin
            strobe(vecs[i].loc);
            tick(2);
         end
         send_frame(vecs[i].nbits, vecs[i].bits, (vecs[i].mode == 2) ? 45 : -1, vecs[i].loc);
         end_frame($sformatf("vec%0d", i), vecs[i].acc, vecs[i].coin, vecs[i].cloc,
                   vecs[i].bits[88:0]);
         if (i == 1) check("vec1_x0", 128'(opponent_data_out[86:76]), 128'(11'b00011101101));
      end

      // Scored frame, then a late strobe must not reach the outputs until the next frame
      check("scored_flag", 128'(opponent_scored_out), 128'(1));
      strobe(L2);
      tick(4);
      check("late_strobe_loc", 128'(player_location_out), 128'(L3));
      send_frame(90, 91'(F2), -1, 63'h0);
      end_frame("after_late", 1'b1, 1'b0, 63'h0, F2[88:0]);
      check("after_late_loc", 128'(player_location_out), 128'(L2));

      // Serial clock toggling while deselected
      data_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_clk_in = 1'b1;
         tick(3);
         data_clk_in = 1'b0;
         tick(3);
      end
      tick(6);
      check("idle_clk_pulses", 128'(pulses), 128'(exp_pulses));
      check_outputs("idle_clk");

      // Reset in the middle of a frame
      send_frame(40, 91'(F1), -1, 63'h0);
      rst_n = 1'b0;
      sel_in = 1'b1;
      data_clk_in = 1'b0;
      tick(1);
      exp_data = '0;
      exp_loc = '0;
      loc_model = '0;
      check_outputs("mid_reset");
      tick(1);
      rst_n = 1'b1;
      tick(4);
      check_outputs("mid_reset_rel");
      send_frame(90, 91'(F1), -1, 63'h0);
      end_frame("after_reset", 1'b1, 1'b0, 63'h0, F1[88:0]);

      check("total_pulses", 128'(pulses), 128'(exp_pulses));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
